// File: rtl/spi_display_tx.sv
// spi_display_tx
//   Memory-mapped transmit engine for the SPI LCD panel. Bytes pushed by the
//   MMU are queued in a small FIFO as {dc, byte} and shifted out in SPI mode 0,
//   MSB first. The D/C line is updated once per byte, only while spi_clk is low.
//
//   Optional build macro: SPI_DISPLAY_RX_EN
//     When defined, spi_miso is sampled on every spi_clk rising edge. At the end
//     of each byte the received value appears on rx_data, with a one-cycle
//     rx_valid pulse during the GAP cycle. When undefined, those ports do not
//     exist and spi_miso drives nothing.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   wr_ena          push one {wr_dc, wr_data} entry (dropped when full)
//   wr_data, wr_dc  byte to send and its D/C level (1 = data, 0 = command)
//   full, empty     registered FIFO flags
//   busy            engine active or FIFO non-empty
//   level           FIFO occupancy
//   overflow        sticky: a write was dropped while full
//   display_csb     panel chip select (active low)
//   data_commandb   panel D/C line
//   spi_clk         SPI clock, idle low
//   spi_mosi        SPI data out
//   spi_miso        SPI data in (optional receive path only)
//   rx_data, rx_valid  received byte and strobe (SPI_DISPLAY_RX_EN only)
//
// Handshake: the write port has no back-pressure. Software must check full
// before writing; a wr_ena while full is discarded and flagged on overflow.
module spi_display_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_ena,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_dc,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          display_csb,
    output logic                          data_commandb,
    output logic                          spi_clk,
    output logic                          spi_mosi,
    input  logic                          spi_miso
`ifdef SPI_DISPLAY_RX_EN
    ,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t         state;
    logic [DW-1:0]  div_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;

    logic [8:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [8:0]     head;
    logic           push;
    logic           pop;
    logic           div_last;
    logic [LW-1:0]  level_next;

    assign head     = mem[rd_ptr];
    assign div_last = (div_cnt == DW'(CLK_DIV - 1));
    assign busy     = (state != S_IDLE) || !empty;

    // Pops happen only where the FSM loads a new byte: IDLE, or GAP for
    // back-to-back bytes. Push is gated on the registered full flag, so a
    // write while full is dropped even if a pop frees a slot that cycle.
    always_comb begin
        pop        = !empty && ((state == S_IDLE) || (state == S_GAP));
        push       = wr_ena && !full;
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (!push && pop) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_dc, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_ena && full) overflow <= 1'b1;
            level <= level_next;
            full  <= (level_next == LW'(FIFO_DEPTH));
            empty <= (level_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            display_csb   <= 1'b1;
            data_commandb <= 1'b1;
            spi_clk       <= 1'b0;
            spi_mosi      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    if (pop) begin
                        shift_reg     <= head[7:0];
                        bit_cnt       <= 3'd7;
                        data_commandb <= head[8];
                        spi_mosi      <= head[7];
                        display_csb   <= 1'b0;
                        div_cnt       <= '0;
                        state         <= S_LOW;
                    end else if (state == S_GAP) begin
                        display_csb <= 1'b1;
                        spi_mosi    <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_LOW: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        spi_clk <= 1'b1;
                        state   <= S_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        spi_clk <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            spi_mosi  <= shift_reg[6];
                            bit_cnt   <= bit_cnt - 1'b1;
                            state     <= S_LOW;
                        end else begin
                            state <= S_GAP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_DISPLAY_RX_EN
    logic [7:0] rx_shift;

    // The sample point is the same edge that raises spi_clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if ((state == S_LOW) && div_last) begin
                rx_shift <= {rx_shift[6:0], spi_miso};
            end
            if ((state == S_HIGH) && div_last && (bit_cnt == 3'd0)) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
`endif

endmodule

// File: tb/tb_spi_display_tx.sv
// Testbench for spi_display_tx (FIFO_DEPTH=16, CLK_DIV=2).
// Inputs change on the falling clock edge and outputs are sampled there too.
module tb_spi_display_tx;

    localparam int FIFO_DEPTH = 16;
    localparam int CLK_DIV    = 2;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          wr_ena;
    logic [7:0]    wr_data;
    logic          wr_dc;
    logic          full;
    logic          empty;
    logic          busy;
    logic [LW-1:0] level;
    logic          overflow;
    logic          display_csb;
    logic          data_commandb;
    logic          spi_clk;
    logic          spi_mosi;
    logic          spi_miso;
`ifdef SPI_DISPLAY_RX_EN
    logic [7:0]    rx_data;
    logic          rx_valid;
`endif

    spi_display_tx #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_ena        (wr_ena),
        .wr_data       (wr_data),
        .wr_dc         (wr_dc),
        .full          (full),
        .empty         (empty),
        .busy          (busy),
        .level         (level),
        .overflow      (overflow),
        .display_csb   (display_csb),
        .data_commandb (data_commandb),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso)
`ifdef SPI_DISPLAY_RX_EN
        ,
        .rx_data       (rx_data),
        .rx_valid      (rx_valid)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];
    int         start_q[$];
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         byte_cnt  = 0;
    int         dc_glitch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- SPI monitor ----------------
    // Rebuilds {dc, byte} from the pins, compares against exp_q, checks the
    // spi_clk high time and that D/C never moves while spi_clk is high.
    initial begin
        logic       prev_sclk;
        logic       prev_dc;
        logic       mon_dc;
        logic [7:0] mon_byte;
        int         mon_bits;
        int         high_cnt;
        prev_sclk = 1'b0;
        prev_dc   = 1'b1;
        mon_dc    = 1'b0;
        mon_byte  = '0;
        mon_bits  = 0;
        high_cnt  = 0;
        forever begin
            @(negedge clk);
            if (display_csb || rst) begin
                mon_bits = 0;
                high_cnt = 0;
            end else begin
                if (spi_clk && prev_sclk && (data_commandb != prev_dc)) dc_glitch++;
                if (spi_clk && !prev_sclk) begin
                    if (mon_bits == 0) begin
                        mon_dc = data_commandb;
                        start_q.push_back(cyc);
                    end else if (data_commandb != mon_dc) begin
                        dc_glitch++;
                    end
                    mon_byte = {mon_byte[6:0], spi_mosi};
                    mon_bits++;
                    if (mon_bits == 8) begin
                        mon_bits = 0;
                        byte_cnt++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL tx_byte_unexpected: got 0x%0h, expected none", {mon_dc, mon_byte});
                        end else begin
                            check("tx_byte", 32'({mon_dc, mon_byte}), 32'(exp_q.pop_front()));
                        end
                    end
                end
                if (spi_clk) begin
                    high_cnt++;
                end else if (prev_sclk) begin
                    check("sclk_high_cycles", 32'(high_cnt), 32'(CLK_DIV));
                    high_cnt = 0;
                end
            end
            prev_sclk = spi_clk;
            prev_dc   = data_commandb;
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a falling edge; returns on the next falling edge.
    task automatic write_byte(input logic [7:0] d, input logic dc);
        wr_data = d;
        wr_dc   = dc;
        wr_ena  = 1'b1;
        @(negedge clk);
        wr_ena  = 1'b0;
    endtask

    // Waits (bounded) for display_csb to return high; reports cycles waited.
    task automatic wait_csb_high(input int limit, output int waited);
        waited = 0;
        while (!display_csb && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        check("csb_returns_high", 32'(display_csb), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       exp_bit7;
        logic [8:0] exp_word;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int waited;
        int b0;
        int act;
        logic [7:0] pat;

        vecs[0] = '{8'h2A, 1'b0, 1'b0, 9'h02A};
        vecs[1] = '{8'h81, 1'b1, 1'b1, 9'h181};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 9'h0FF};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 9'h100};
        vecs[4] = '{8'h5A, 1'b1, 1'b0, 9'h15A};

        rst      = 1'b1;
        wr_ena   = 1'b0;
        wr_data  = '0;
        wr_dc    = 1'b0;
        spi_miso = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_full",     32'(full),          32'd0);
        check("rst_empty",    32'(empty),         32'd1);
        check("rst_level",    32'(level),         32'd0);
        check("rst_busy",     32'(busy),          32'd0);
        check("rst_overflow", 32'(overflow),      32'd0);
        check("rst_csb",      32'(display_csb),   32'd1);
        check("rst_sclk",     32'(spi_clk),       32'd0);
        check("rst_mosi",     32'(spi_mosi),      32'd0);
        check("rst_dc",       32'(data_commandb), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single bytes from the table.
        for (int i = 0; i < 5; i++) begin
            b0 = byte_cnt;
            exp_q.push_back(vecs[i].exp_word);
            write_byte(vecs[i].data, vecs[i].dc);
            check("after_write_csb",   32'(display_csb), 32'd1);
            check("after_write_empty", 32'(empty),       32'd0);
            check("after_write_busy",  32'(busy),        32'd1);
            @(negedge clk);
            check("start_csb",  32'(display_csb),   32'd0);
            check("start_mosi", 32'(spi_mosi),      32'(vecs[i].exp_bit7));
            check("start_dc",   32'(data_commandb), 32'(vecs[i].dc));
            check("start_sclk", 32'(spi_clk),       32'd0);
            wait_csb_high(200, waited);
            // csb was low on 33 falling edges; the first was seen above.
            check("single_csb_low_len", 32'(waited), 32'd33);
            check("idle_busy",  32'(busy),          32'd0);
            check("idle_empty", 32'(empty),         32'd1);
            check("idle_mosi",  32'(spi_mosi),      32'd0);
            check("idle_dc_hold", 32'(data_commandb), 32'(vecs[i].dc));
            check("single_byte_count", 32'(byte_cnt - b0), 32'd1);
            repeat (3) @(negedge clk);
        end

        // Back-to-back burst: 0x2C cmd, then 0xF8, 0x00 data.
        start_q.delete();
        dc_glitch = 0;
        exp_q.push_back(9'h02C);
        exp_q.push_back(9'h1F8);
        exp_q.push_back(9'h100);
        wr_ena = 1'b1; wr_data = 8'h2C; wr_dc = 1'b0;
        @(negedge clk);
        wr_data = 8'hF8; wr_dc = 1'b1;
        @(negedge clk);
        wr_data = 8'h00; wr_dc = 1'b1;
        @(negedge clk);
        wr_ena = 1'b0;
        check("burst_csb_low", 32'(display_csb), 32'd0);
        wait_csb_high(400, waited);
        // csb low for 99 edges; two of them were already consumed above.
        check("burst_csb_low_len", 32'(waited), 32'd98);
        check("burst_start_count", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("burst_spacing_1", 32'(start_q[1] - start_q[0]), 32'd33);
            check("burst_spacing_2", 32'(start_q[2] - start_q[1]), 32'd33);
        end
        check("burst_dc_glitch", 32'(dc_glitch), 32'd0);
        repeat (3) @(negedge clk);

        // Fill while the engine is busy on one byte: 17 writes, last dropped.
        b0 = byte_cnt;
        exp_q.push_back(9'h0C3);
        write_byte(8'hC3, 1'b0);
        @(negedge clk);
        check("fill_engine_busy", 32'(display_csb), 32'd0);
        for (int i = 0; i < 17; i++) begin
            wr_ena  = 1'b1;
            wr_data = 8'(i + 1);
            wr_dc   = 1'b1;
            if (i < 16) exp_q.push_back({1'b1, 8'(i + 1)});
            @(negedge clk);
            if (i == 15) begin
                check("fill_full_at_16",  32'(full),     32'd1);
                check("fill_level_16",    32'(level),    32'd16);
                check("fill_no_overflow", 32'(overflow), 32'd0);
            end
            if (i == 16) begin
                check("fill_overflow_set", 32'(overflow), 32'd1);
                check("fill_level_stays",  32'(level),    32'd16);
            end
        end
        wr_ena = 1'b0;
        wait_csb_high(1000, waited);
        check("fill_bytes_sent",   32'(byte_cnt - b0),  32'd17);
        check("fill_queue_done",   32'(exp_q.size()),   32'd0);
        check("overflow_sticky",   32'(overflow),       32'd1);
        check("fill_drained_full", 32'(full),           32'd0);
        pulse_reset();
        check("overflow_cleared",  32'(overflow),       32'd0);

        // Reset during bit 4 of 0xA5 with three more bytes queued.
        b0 = byte_cnt;
        wr_ena = 1'b1; wr_data = 8'hA5; wr_dc = 1'b1;
        @(negedge clk);
        wr_data = 8'h01;
        @(negedge clk);
        wr_data = 8'h02;
        @(negedge clk);
        wr_data = 8'h03;
        @(negedge clk);
        wr_ena = 1'b0;
        check("midrst_level_3", 32'(level), 32'd3);
        repeat (11) @(negedge clk);
        check("midrst_active", 32'(display_csb), 32'd0);
        pulse_reset();
        check("midrst_csb",      32'(display_csb), 32'd1);
        check("midrst_sclk",     32'(spi_clk),     32'd0);
        check("midrst_level",    32'(level),       32'd0);
        check("midrst_overflow", 32'(overflow),    32'd0);
        check("midrst_empty",    32'(empty),       32'd1);
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (spi_clk || !display_csb) act++;
        end
        check("midrst_no_activity", 32'(act), 32'd0);
        check("midrst_no_bytes",    32'(byte_cnt - b0), 32'd0);

        // Push in the same cycle as the GAP pop, at level 1.
        exp_q.push_back(9'h13C);
        exp_q.push_back(9'h196);
        exp_q.push_back(9'h069);
        write_byte(8'h3C, 1'b1);
        @(negedge clk);
        write_byte(8'h96, 1'b1);
        check("pp_level_1", 32'(level), 32'd1);
        repeat (31) @(negedge clk);
        check("pp_gap_sclk",  32'(spi_clk),     32'd0);
        check("pp_gap_csb",   32'(display_csb), 32'd0);
        check("pp_gap_level", 32'(level),       32'd1);
        write_byte(8'h69, 1'b0);
        check("pp_level_kept", 32'(level),       32'd1);
        check("pp_csb_low",    32'(display_csb), 32'd0);
        wait_csb_high(400, waited);
        check("pp_queue_done", 32'(exp_q.size()), 32'd0);

`ifdef SPI_DISPLAY_RX_EN
        // Receive 0x5A while sending 0x00; MISO changes after each fall.
        begin
            int   idx;
            int   pulses;
            logic prev;
            logic [7:0] got;
            pat    = 8'h5A;
            idx    = 0;
            pulses = 0;
            got    = '0;
            prev   = 1'b0;
            spi_miso = pat[7];
            exp_q.push_back(9'h000);
            write_byte(8'h00, 1'b0);
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (rx_valid) begin
                    pulses++;
                    got = rx_data;
                end
                if (prev && !spi_clk) begin
                    idx++;
                    if (idx < 8) spi_miso = pat[7 - idx];
                end
                prev = spi_clk;
                if (display_csb && idx >= 8) break;
            end
            check("rx_pulses", 32'(pulses), 32'd1);
            check("rx_data",   32'(got),    32'h5A);
            spi_miso = 1'b0;
        end
`else
        pat = 8'h00;
        spi_miso = pat[0];
`endif

        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
